// File: rtl/pzcorebus_packed_serializer.sv
// Serializes one packed corebus channel word into LINK_WIDTH-bit link beats, LSB slice first.
// Define PZCOREBUS_PACKED_SERIALIZER_PARITY_EN to add an even-parity output per beat.
module pzcorebus_packed_serializer #(
    parameter int PACKED_WIDTH = 64,
    parameter int LINK_WIDTH   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_accept,
    input  logic [PACKED_WIDTH-1:0] i_data,
    output logic                    o_link_valid,
    input  logic                    i_link_accept,
    output logic [LINK_WIDTH-1:0]   o_link_data,
    output logic                    o_link_last,
    output logic                    o_busy
`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
    ,
    output logic                    o_link_parity
`endif
);

    // state | meaning
    // IDLE  | no word held
    // SEND  | word held, count = index of the beat being presented

    localparam int BEATS_RAW   = (PACKED_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
    localparam int BEATS       = (BEATS_RAW > 1) ? BEATS_RAW : 1;
    localparam int COUNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int HOLD_WIDTH  = BEATS * LINK_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                               state;
    state_t                               state_next;
    logic [COUNT_WIDTH-1:0]               count;
    logic [COUNT_WIDTH-1:0]               count_next;
    logic [BEATS-1:0][LINK_WIDTH-1:0]     hold;
    logic [HOLD_WIDTH-1:0]                data_ext;
    logic                                 load;
    logic                                 beat_done;

    always_comb begin
        data_ext                   = '0;
        data_ext[PACKED_WIDTH-1:0] = i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            count <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (load) begin
                hold <= data_ext;
            end
        end
    end

    assign load      = i_valid && o_accept;
    assign beat_done = o_link_valid && i_link_accept;

    // A load on the last beat restarts the counter, giving zero-bubble back-to-back words.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = SEND;
                    count_next = '0;
                end
            end
            SEND: begin
                if (beat_done) begin
                    if (o_link_last) begin
                        state_next = load ? SEND : IDLE;
                        count_next = '0;
                    end else begin
                        count_next = count + COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        o_link_valid = (state == SEND);
        o_busy       = (state == SEND);
        o_link_last  = (state == SEND) && (count == LAST_COUNT);
        o_link_data  = hold[count];
        o_accept     = !i_rst && ((state == IDLE) || (o_link_last && i_link_accept));
    end

`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
    assign o_link_parity = ^o_link_data;
`endif

endmodule

// File: tb/tb_pzcorebus_packed_serializer.sv
// Scoreboard bench: a 64/16 instance for the main tests and a 40/16 instance for padding.
// Parity checks are compiled in with PZCOREBUS_PACKED_SERIALIZER_PARITY_EN.
module tb_pzcorebus_packed_serializer;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_accept;
    logic [63:0] i_data;
    logic        o_link_valid;
    logic        i_link_accept;
    logic [15:0] o_link_data;
    logic        o_link_last;
    logic        o_busy;

    logic        p_valid;
    logic        p_accept;
    logic [39:0] p_data;
    logic        p_link_valid;
    logic        p_link_accept;
    logic [15:0] p_link_data;
    logic        p_link_last;
    logic        p_busy;

`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
    logic        o_link_parity;
    logic        p_link_parity;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    beat_t exp_q[$];
    beat_t p_q[$];

    pzcorebus_packed_serializer #(.PACKED_WIDTH(64), .LINK_WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_accept(o_accept), .i_data(i_data),
        .o_link_valid(o_link_valid), .i_link_accept(i_link_accept), .o_link_data(o_link_data),
        .o_link_last(o_link_last), .o_busy(o_busy)
`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
        , .o_link_parity(o_link_parity)
`endif
    );

    pzcorebus_packed_serializer #(.PACKED_WIDTH(40), .LINK_WIDTH(16)) dut_pad (
        .i_clk(clk), .i_rst(rst), .i_valid(p_valid), .o_accept(p_accept), .i_data(p_data),
        .o_link_valid(p_link_valid), .i_link_accept(p_link_accept), .o_link_data(p_link_data),
        .o_link_last(p_link_last), .o_busy(p_busy)
`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
        , .o_link_parity(p_link_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2, input logic [15:0] b3);
        exp_q.push_back('{b0, 1'b0});
        exp_q.push_back('{b1, 1'b0});
        exp_q.push_back('{b2, 1'b0});
        exp_q.push_back('{b3, 1'b1});
    endtask

    // Holds i_valid/i_data until accepted; returns at posedge+1 with i_valid still high.
    task automatic offer(input logic [63:0] d, output int waited);
        waited  = 0;
        i_valid = 1'b1;
        i_data  = d;
        do begin
            @(negedge clk);
            waited++;
        end while (!o_accept && waited < 50);
        check("accept_timeout", {63'd0, o_accept}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 64/16 instance: pops on each transferred beat, checks hold under backpressure.
    initial begin
        beat_t       e;
        logic        held = 1'b0;
        logic [15:0] held_data = '0;
        forever begin
            @(negedge clk);
            if (o_link_valid && i_link_accept) begin
                if (exp_q.size() == 0) begin
                    check("beat_queue", 64'd0, 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", {48'd0, o_link_data}, {48'd0, e.data});
                    check("beat_last", {63'd0, o_link_last}, {63'd0, e.last});
`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
                    check("beat_parity", {63'd0, o_link_parity}, {63'd0, ^e.data});
`endif
                end
            end
            if (held && o_link_valid) begin
                check("bp_stable", {48'd0, o_link_data}, {48'd0, held_data});
            end
            held      = o_link_valid && !i_link_accept && !rst;
            held_data = o_link_data;
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (p_link_valid && p_link_accept) begin
                if (p_q.size() == 0) begin
                    check("pad_queue", 64'd0, 64'd1);
                end else begin
                    e = p_q.pop_front();
                    check("pad_data", {48'd0, p_link_data}, {48'd0, e.data});
                    check("pad_last", {63'd0, p_link_last}, {63'd0, e.last});
                end
            end
        end
    end

    initial begin
        int w;
        int guard;
        rst           = 1'b1;
        i_valid       = 1'b0;
        i_data        = '0;
        i_link_accept = 1'b1;
        p_valid       = 1'b0;
        p_data        = '0;
        p_link_accept = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'd0, o_link_valid}, 64'd0);
        check("rst_last", {63'd0, o_link_last}, 64'd0);
        check("rst_data", {48'd0, o_link_data}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_accept", {63'd0, o_accept}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("accept_after_reset", {63'd0, o_accept}, 64'd1);
        @(posedge clk);
        #1;

        // Single word
        offer(64'h1122_3344_5566_7788, w);
        i_valid = 1'b0;
        push4(16'h7788, 16'h5566, 16'h3344, 16'h1122);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("single_accept_low", {63'd0, o_accept}, 64'd0);
            check("single_valid", {63'd0, o_link_valid}, 64'd1);
`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
            if (i == 0) check("parity_7788", {63'd0, o_link_parity}, 64'd0);
`endif
        end
        @(negedge clk);
        check("single_last", {63'd0, o_link_last}, 64'd1);
        check("single_accept_last", {63'd0, o_accept}, 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back
        offer(64'hAAAA_AAAA_AAAA_AAAA, w);
        push4(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        offer(64'h5555_5555_5555_5555, w);
        check("b2b_accept_cycle", 64'(w), 64'd4);
        push4(16'h5555, 16'h5555, 16'h5555, 16'h5555);
        i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_no_gap", {63'd0, o_link_valid}, 64'd1);
        end
        @(posedge clk);
        #1;

        // Backpressure on beat 1
        offer(64'h1122_3344_5566_7788, w);
        i_valid = 1'b0;
        push4(16'h7788, 16'h5566, 16'h3344, 16'h1122);
        @(posedge clk);
        #1 i_link_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_data", {48'd0, o_link_data}, 64'h5566);
            check("bp_last", {63'd0, o_link_last}, 64'd0);
        end
        @(posedge clk);
        #1 i_link_accept = 1'b1;
        repeat (3) @(posedge clk);
        #1;

`ifdef PZCOREBUS_PACKED_SERIALIZER_PARITY_EN
        offer(64'h0000_0000_0000_0001, w);
        i_valid = 1'b0;
        push4(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        check("parity_0001", {63'd0, o_link_parity}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
`endif

        // Padding on the 40/16 instance
        p_valid = 1'b1;
        p_data  = 40'hFF_1234_5678;
        guard   = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!p_accept && guard < 50);
        check("pad_accept", {63'd0, p_accept}, 64'd1);
        @(posedge clk);
        #1 p_valid = 1'b0;
        p_q.push_back('{16'h5678, 1'b0});
        p_q.push_back('{16'h1234, 1'b0});
        p_q.push_back('{16'h00FF, 1'b1});
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-word after beat 1 transfers
        offer(64'h1122_3344_5566_7788, w);
        i_valid = 1'b0;
        push4(16'h7788, 16'h5566, 16'h3344, 16'h1122);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("accept_in_reset", {63'd0, o_accept}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_leftover", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", {63'd0, o_link_valid}, 64'd0);
        check("midrst_last", {63'd0, o_link_last}, 64'd0);
        check("midrst_data", {48'd0, o_link_data}, 64'd0);
        check("midrst_accept", {63'd0, o_accept}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("accept_after_midrst", {63'd0, o_accept}, 64'd1);

        guard = 0;
        while ((exp_q.size() != 0 || p_q.size() != 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("drain_main", 64'(exp_q.size()), 64'd0);
        check("drain_pad", 64'(p_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
